// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions used by the instruction-fetch stage:
// reset PC default, the NOP encoding, the fetch FSM state type and
// small PC helpers.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_FULL,
        ST_DRAIN
    } fetch_state_t;

    // Sequential successor of a word address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Branch/jump targets are word addresses; the low two bits are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch port. The fetch stage is the master: it issues a
// request (valid/addr) that the memory accepts with ready, and the memory
// answers in order with a valid/data response at least one cycle later.
interface if_fetch_stage_if;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, keeps at
// most one instruction-memory request outstanding, and presents a registered
// {pc+4, instruction} slot to the IF/ID register. A one-entry skid register
// catches a response that arrives while ID is stalled, and redirects from ID
// flush the slot, the skid entry and any response still in flight.
module if_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_stall,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    if_fetch_stage_if.master        imem,
    output logic                    o_valid,
    output logic [31:0]             o_pc_plus_4,
    output logic [31:0]             o_instruction
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_inc;

    logic        skid_valid;
    logic [31:0] skid_pc_plus_4;
    logic [31:0] skid_instr;
    logic        skid_valid_next;
    logic [31:0] skid_pc_plus_4_next;
    logic [31:0] skid_instr_next;

    logic        slot_valid_next;
    logic [31:0] slot_pc_plus_4_next;
    logic [31:0] slot_instr_next;

    logic        slot_free;
    logic        redirect_take;
    logic        rsp_valid;

    assign pc_inc        = next_pc(pc);
    assign slot_free     = !o_valid || !if_stall;
    assign redirect_take = redirect_valid && (state != ST_IDLE);
    assign rsp_valid     = imem.imem_rsp_valid;

    // The request is a pure decode of REQ; the address always tracks the PC so
    // a redirect while waiting for ready changes the pending request.
    always_comb begin
        imem.imem_req_valid = (state == ST_REQ);
        imem.imem_addr      = pc;
    end

    // Next-state, PC, skid and slot computation. A consumed slot empties unless
    // something refills it; a redirect overrides everything below it.
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        skid_valid_next     = skid_valid;
        skid_pc_plus_4_next = skid_pc_plus_4;
        skid_instr_next     = skid_instr;
        slot_valid_next     = o_valid;
        slot_pc_plus_4_next = o_pc_plus_4;
        slot_instr_next     = o_instruction;

        if (o_valid && !if_stall) begin
            slot_valid_next = 1'b0;
            slot_instr_next = NOP_INSTR;
        end

        case (state)
            ST_IDLE: begin
                state_next = ST_REQ;
            end

            ST_REQ: begin
                if (imem.imem_req_ready) begin
                    state_next = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) begin
                    state_next = rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (rsp_valid) begin
                    pc_next = pc_inc;
                    if (slot_free) begin
                        slot_valid_next     = 1'b1;
                        slot_pc_plus_4_next = pc_inc;
                        slot_instr_next     = imem.imem_rsp_data;
                        state_next          = ST_REQ;
                    end else begin
                        skid_valid_next     = 1'b1;
                        skid_pc_plus_4_next = pc_inc;
                        skid_instr_next     = imem.imem_rsp_data;
                        state_next          = ST_FULL;
                    end
                end
            end

            ST_FULL: begin
                if (redirect_valid) begin
                    skid_valid_next = 1'b0;
                    state_next      = ST_REQ;
                end else if (slot_free) begin
                    slot_valid_next     = 1'b1;
                    slot_pc_plus_4_next = skid_pc_plus_4;
                    slot_instr_next     = skid_instr;
                    skid_valid_next     = 1'b0;
                    state_next          = ST_REQ;
                end
            end

            ST_DRAIN: begin
                if (rsp_valid) begin
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (redirect_take) begin
            pc_next         = align_word(redirect_pc);
            slot_valid_next = 1'b0;
            slot_instr_next = NOP_INSTR;
            skid_valid_next = 1'b0;
        end
    end

    // State register: FSM, PC, skid entry and the registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            skid_valid     <= 1'b0;
            skid_pc_plus_4 <= RESET_PC;
            skid_instr     <= NOP_INSTR;
            o_valid        <= 1'b0;
            o_pc_plus_4    <= RESET_PC;
            o_instruction  <= NOP_INSTR;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            skid_valid     <= skid_valid_next;
            skid_pc_plus_4 <= skid_pc_plus_4_next;
            skid_instr     <= skid_instr_next;
            o_valid        <= slot_valid_next;
            o_pc_plus_4    <= slot_pc_plus_4_next;
            o_instruction  <= slot_instr_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage. A small instruction memory
// returns {16'hC0DE, addr[15:0]} for every fetch, with a programmable number
// of extra latency cycles. Inputs change and outputs are checked on negedges.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        if_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        o_valid;
    logic [31:0] o_pc_plus_4;
    logic [31:0] o_instruction;

    int total;
    int bad;

    int          mem_extra;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic [31:0] last_acc_addr;

    if_fetch_stage_if mem_bus ();

    if_fetch_stage #(
        .RESET_PC(32'h0000_3000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mem_bus),
        .o_valid        (o_valid),
        .o_pc_plus_4    (o_pc_plus_4),
        .o_instruction  (o_instruction)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: responds on the negedge after acceptance plus mem_extra
    // cycles; acceptance is judged shortly before each posedge.
    initial begin
        mem_bus.imem_rsp_valid = 1'b0;
        mem_bus.imem_rsp_data  = 32'h0;
        pend          = 1'b0;
        pend_cnt      = 0;
        pend_addr     = 32'h0;
        last_acc_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (pend && pend_cnt == 0) begin
                mem_bus.imem_rsp_valid = 1'b1;
                mem_bus.imem_rsp_data  = mem_word(pend_addr);
                pend = 1'b0;
            end else begin
                mem_bus.imem_rsp_valid = 1'b0;
                mem_bus.imem_rsp_data  = 32'hDEAD_BEEF;
                if (pend) pend_cnt = pend_cnt - 1;
            end
            #3;
            if (rst) begin
                pend = 1'b0;
            end else if (mem_bus.imem_req_valid && mem_bus.imem_req_ready) begin
                pend          = 1'b1;
                pend_cnt      = mem_extra;
                pend_addr     = mem_bus.imem_addr;
                last_acc_addr = mem_bus.imem_addr;
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut(input int cycles);
        @(negedge clk);
        rst                    = 1'b1;
        if_stall               = 1'b0;
        redirect_valid         = 1'b0;
        redirect_pc            = 32'h0;
        mem_extra              = 0;
        mem_bus.imem_req_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst                    = 1'b1;
        if_stall               = 1'b0;
        redirect_valid         = 1'b0;
        redirect_pc            = 32'h0;
        mem_extra              = 0;
        mem_bus.imem_req_ready = 1'b1;
        repeat (3) step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_req_valid} !== {1'b0, 32'h0000_3000, 32'h0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_values: got v=%0b pc4=%h ins=%h req=%0b, want v=0 pc4=00003000 ins=00000000 req=0",
                     o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_req_valid);
        end
        rst = 1'b0;
        step();
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b1, 32'h0000_3000}) begin
            bad++;
            $display("[TB] FAIL first_request: got req=%0b addr=%h, want req=1 addr=00003000",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b0, 32'h0000_3000, 32'h0}) begin
            bad++;
            $display("[TB] FAIL idle_outputs: got v=%0b pc4=%h ins=%h, want v=0 pc4=00003000 ins=00000000",
                     o_valid, o_pc_plus_4, o_instruction);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3004, 32'hC0DE_3000}) begin
            bad++;
            $display("[TB] FAIL startup_slot0: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003004 ins=c0de3000",
                     o_valid, o_pc_plus_4, o_instruction);
        end
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b0, 32'h0000_3004, 32'h0}) begin
            bad++;
            $display("[TB] FAIL startup_bubble: got v=%0b pc4=%h ins=%h, want v=0 pc4=00003004 ins=00000000",
                     o_valid, o_pc_plus_4, o_instruction);
        end
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3008, 32'hC0DE_3004}) begin
            bad++;
            $display("[TB] FAIL startup_slot1: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003008 ins=c0de3004",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_stall();
        reset_dut(2);
        repeat (3) step();
        if_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3004, 32'hC0DE_3000}) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003004 ins=c0de3000",
                         i, o_valid, o_pc_plus_4, o_instruction);
            end
            if (i == 1) begin
                total++;
                if (mem_bus.imem_req_valid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stall_full_no_req: got req=%0b, want req=0", mem_bus.imem_req_valid);
                end
            end
        end
        if_stall = 1'b0;
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_addr} !== {1'b1, 32'h0000_3008, 32'hC0DE_3004, 32'h0000_3008}) begin
            bad++;
            $display("[TB] FAIL stall_skid_out: got v=%0b pc4=%h ins=%h addr=%h, want v=1 pc4=00003008 ins=c0de3004 addr=00003008",
                     o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_addr);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_300C, 32'hC0DE_3008}) begin
            bad++;
            $display("[TB] FAIL stall_next: got v=%0b pc4=%h ins=%h, want v=1 pc4=0000300c ins=c0de3008",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_redirect_wait();
        reset_dut(2);
        repeat (5) step();
        if_stall = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3100;
        step();
        redirect_valid = 1'b0;
        if_stall       = 1'b0;
        total++;
        if ({o_valid, o_instruction} !== {1'b0, 32'h0}) begin
            bad++;
            $display("[TB] FAIL redir_wait_nop: got v=%0b ins=%h, want v=0 ins=00000000", o_valid, o_instruction);
        end
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b1, 32'h0000_3100}) begin
            bad++;
            $display("[TB] FAIL redir_wait_addr: got req=%0b addr=%h, want req=1 addr=00003100",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3104, 32'hC0DE_3100}) begin
            bad++;
            $display("[TB] FAIL redir_wait_target: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003104 ins=c0de3100",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_redirect_full();
        reset_dut(2);
        repeat (3) step();
        if_stall = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        step();
        redirect_valid = 1'b0;
        if_stall       = 1'b0;
        total++;
        if ({o_valid, o_instruction, mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b0, 32'h0, 1'b1, 32'h0000_3200}) begin
            bad++;
            $display("[TB] FAIL redir_full_flush: got v=%0b ins=%h req=%0b addr=%h, want v=0 ins=00000000 req=1 addr=00003200",
                     o_valid, o_instruction, mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3204, 32'hC0DE_3200}) begin
            bad++;
            $display("[TB] FAIL redir_full_target: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003204 ins=c0de3200",
                     o_valid, o_pc_plus_4, o_instruction);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3208, 32'hC0DE_3204}) begin
            bad++;
            $display("[TB] FAIL redir_full_next: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003208 ins=c0de3204",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_backpressure();
        reset_dut(2);
        mem_bus.imem_req_ready = 1'b0;
        step();
        step();
        step();
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b1, 32'h0000_3000}) begin
            bad++;
            $display("[TB] FAIL bp_hold_addr: got req=%0b addr=%h, want req=1 addr=00003000",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b1, 32'h0000_4000}) begin
            bad++;
            $display("[TB] FAIL bp_changed_addr: got req=%0b addr=%h, want req=1 addr=00004000",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        step();
        step();
        mem_bus.imem_req_ready = 1'b1;
        step();
        total++;
        if (last_acc_addr !== 32'h0000_4000) begin
            bad++;
            $display("[TB] FAIL bp_accepted_addr: got %h, want 00004000", last_acc_addr);
        end
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_4004, 32'hC0DE_4000}) begin
            bad++;
            $display("[TB] FAIL bp_slot: got v=%0b pc4=%h ins=%h, want v=1 pc4=00004004 ins=c0de4000",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_drain();
        reset_dut(2);
        mem_extra = 2;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3300;
        step();
        redirect_valid = 1'b0;
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b0, 32'h0000_3300}) begin
            bad++;
            $display("[TB] FAIL drain_wait: got req=%0b addr=%h, want req=0 addr=00003300",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        step();
        mem_extra = 0;
        step();
        total++;
        if ({o_valid, o_instruction, mem_bus.imem_req_valid} !== {1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL drain_discard: got v=%0b ins=%h req=%0b, want v=0 ins=00000000 req=1",
                     o_valid, o_instruction, mem_bus.imem_req_valid);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3304, 32'hC0DE_3300}) begin
            bad++;
            $display("[TB] FAIL drain_target: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003304 ins=c0de3300",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    task automatic test_wrap();
        reset_dut(2);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        total++;
        if (mem_bus.imem_addr !== 32'hFFFF_FFFC) begin
            bad++;
            $display("[TB] FAIL wrap_aligned_addr: got %h, want fffffffc", mem_bus.imem_addr);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_addr} !== {1'b1, 32'h0, 32'hC0DE_FFFC, 32'h0}) begin
            bad++;
            $display("[TB] FAIL wrap_slot: got v=%0b pc4=%h ins=%h addr=%h, want v=1 pc4=00000000 ins=c0defffc addr=00000000",
                     o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid_wait();
        reset_dut(2);
        repeat (5) step();
        if_stall = 1'b1;
        step();
        rst      = 1'b1;
        if_stall = 1'b0;
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_req_valid} !== {1'b0, 32'h0000_3000, 32'h0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset_values: got v=%0b pc4=%h ins=%h req=%0b, want v=0 pc4=00003000 ins=00000000 req=0",
                     o_valid, o_pc_plus_4, o_instruction, mem_bus.imem_req_valid);
        end
        rst = 1'b0;
        step();
        total++;
        if ({mem_bus.imem_req_valid, mem_bus.imem_addr} !== {1'b1, 32'h0000_3000}) begin
            bad++;
            $display("[TB] FAIL midreset_restart: got req=%0b addr=%h, want req=1 addr=00003000",
                     mem_bus.imem_req_valid, mem_bus.imem_addr);
        end
        step();
        step();
        total++;
        if ({o_valid, o_pc_plus_4, o_instruction} !== {1'b1, 32'h0000_3004, 32'hC0DE_3000}) begin
            bad++;
            $display("[TB] FAIL midreset_slot: got v=%0b pc4=%h ins=%h, want v=1 pc4=00003004 ins=c0de3000",
                     o_valid, o_pc_plus_4, o_instruction);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_full();
        test_backpressure();
        test_drain();
        test_wrap();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
